// File: rtl/counter_prog.sv
// counter_prog: parametrised up/down counter with load, prescaler,
// wrap/saturate, tc pulse and sticky ovf. Macro COUNTER_PROG_CAPTURE_EN adds cap/cap_out.
module counter_prog #(
  parameter int unsigned      WIDTH    = 64,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE = 1,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             d_en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
`ifdef COUNTER_PROG_CAPTURE_EN
  input  logic             cap,
  output logic [WIDTH-1:0] cap_out,
`endif
  output logic [WIDTH-1:0] d_out,
  output logic             tc,
  output logic             ovf
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0] PS_LAST =
    PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PS_ZERO = '0;
  localparam logic [PW-1:0] PS_ONE  = PW'(1);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_next;
  logic             pre_wrap;
  logic             step;
  logic             at_max;
  logic             at_min;
  logic             boundary;
  logic [WIDTH-1:0] load_clamp;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             ovf_next;

  // Prescaler: counts enabled cycles, a step fires on the last phase
  always_comb begin
    pre_wrap = (pre == PS_LAST);
    step     = d_en & pre_wrap & ~load;
    pre_next = pre;
    if (load) begin
      pre_next = PS_ZERO;
    end else if (d_en) begin
      if (pre_wrap) begin
        pre_next = PS_ZERO;
      end else begin
        pre_next = pre + PS_ONE;
      end
    end
  end

  // Candidate step values in both directions with boundary handling
  always_comb begin
    at_max = (d_out == MAX_VAL);
    at_min = (d_out == ZERO);

    if (at_max) begin
      up_val = SATURATE ? MAX_VAL : ZERO;
    end else begin
      up_val = d_out + ONE;
    end

    if (at_min) begin
      dn_val = SATURATE ? ZERO : MAX_VAL;
    end else begin
      dn_val = d_out - ONE;
    end

    step_val = up_dn ? up_val : dn_val;
  end

  // Next count, tc and ovf: load beats step beats hold
  always_comb begin
    if (load_val > MAX_VAL) begin
      load_clamp = MAX_VAL;
    end else begin
      load_clamp = load_val;
    end

    boundary = step & (up_dn ? at_max : at_min);

    count_next = d_out;
    if (load) begin
      count_next = load_clamp;
    end else if (step) begin
      count_next = step_val;
    end

    tc_next  = boundary;
    ovf_next = boundary | (ovf & ~clr_ovf);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!rst) begin
      d_out <= ZERO;
      pre   <= PS_ZERO;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      d_out <= count_next;
      pre   <= pre_next;
      tc    <= tc_next;
      ovf   <= ovf_next;
    end
  end

`ifdef COUNTER_PROG_CAPTURE_EN
  // Capture the count as it stood before this edge's update
  always_ff @(posedge clock) begin
    if (!rst) begin
      cap_out <= ZERO;
    end else if (cap) begin
      cap_out <= d_out;
    end
  end
`endif

endmodule

// File: tb/tb_counter_prog.sv
// tb_counter_prog: three counter_prog instances (wrap, prescale-3, saturate)
// sharing stimulus, checked against an arithmetic model plus literal points.
module tb_counter_prog;

  localparam int W    = 8;
  localparam int MAXV = 9;
  localparam int N    = 3;

  logic         clock = 1'b0;
  logic         rst;
  logic         d_en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic         clr_ovf;
  logic         cap;

  logic [W-1:0] dq [N];
  logic [N-1:0] tcv;
  logic [N-1:0] ovv;
`ifdef COUNTER_PROG_CAPTURE_EN
  logic [W-1:0] cq [N];
`endif

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  int ps_of  [N] = '{1, 3, 1};
  bit sat_of [N] = '{1'b0, 1'b0, 1'b1};

  int mc   [N] = '{0, 0, 0};
  int mp   [N] = '{0, 0, 0};
  int mt   [N] = '{0, 0, 0};
  int mo   [N] = '{0, 0, 0};
  int mcap [N] = '{0, 0, 0};

  always #5 clock = ~clock;

  counter_prog #(
    .WIDTH(W), .MAX_VAL(8'd9),
    .PRESCALE(1), .SATURATE(1'b0)
  ) u_a (
    .clock(clock), .rst(rst), .d_en(d_en),
    .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
`ifdef COUNTER_PROG_CAPTURE_EN
    .cap(cap), .cap_out(cq[0]),
`endif
    .d_out(dq[0]), .tc(tcv[0]), .ovf(ovv[0])
  );

  counter_prog #(
    .WIDTH(W), .MAX_VAL(8'd9),
    .PRESCALE(3), .SATURATE(1'b0)
  ) u_b (
    .clock(clock), .rst(rst), .d_en(d_en),
    .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
`ifdef COUNTER_PROG_CAPTURE_EN
    .cap(cap), .cap_out(cq[1]),
`endif
    .d_out(dq[1]), .tc(tcv[1]), .ovf(ovv[1])
  );

  counter_prog #(
    .WIDTH(W), .MAX_VAL(8'd9),
    .PRESCALE(1), .SATURATE(1'b1)
  ) u_c (
    .clock(clock), .rst(rst), .d_en(d_en),
    .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
`ifdef COUNTER_PROG_CAPTURE_EN
    .cap(cap), .cap_out(cq[2]),
`endif
    .d_out(dq[2]), .tc(tcv[2]), .ovf(ovv[2])
  );

  task automatic chk(string nm, longint act, longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: count as plain integer arithmetic on 0..MAXV
  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      int  c;
      int  nxt;
      bit  bnd;
      c   = mc[i];
      bnd = 1'b0;
      if (!rst) begin
        mc[i] = 0; mp[i] = 0; mt[i] = 0;
        mo[i] = 0; mcap[i] = 0;
      end else begin
        if (cap) mcap[i] = c;
        if (load) begin
          mc[i] = (int'(load_val) > MAXV) ?
                  MAXV : int'(load_val);
          mp[i] = 0;
        end else if (d_en) begin
          mp[i] = (mp[i] + 1) % ps_of[i];
          if (mp[i] == 0) begin
            if (up_dn) begin
              bnd = (c == MAXV);
              nxt = sat_of[i] ?
                    ((c + 1 > MAXV) ? MAXV : c + 1) :
                    (c + 1) % (MAXV + 1);
            end else begin
              bnd = (c == 0);
              nxt = sat_of[i] ?
                    ((c - 1 < 0) ? 0 : c - 1) :
                    (c + MAXV) % (MAXV + 1);
            end
            mc[i] = nxt;
          end
        end
        mt[i] = bnd ? 1 : 0;
        if (bnd) mo[i] = 1;
        else if (clr_ovf) mo[i] = 0;
      end
    end
  end

  // Compare process: every output of every instance, every cycle
  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("d_out[%0d]", i), int'(dq[i]), mc[i]);
        chk($sformatf("tc[%0d]", i), int'(tcv[i]), mt[i]);
        chk($sformatf("ovf[%0d]", i), int'(ovv[i]), mo[i]);
`ifdef COUNTER_PROG_CAPTURE_EN
        chk($sformatf("cap_out[%0d]", i),
            int'(cq[i]), mcap[i]);
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int e;
    bit pat [11] = '{1,1,1,1,0,0,1,1,1,1,1};

    rst = 1'b0; d_en = 1'b1; up_dn = 1'b1;
    load = 1'b1; load_val = 8'h55;
    clr_ovf = 1'b0; cap = 1'b0;

    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_d", int'(dq[0]), 0);
    chk("rst_tc", int'(tcv[0]), 0);
    chk("rst_ovf", int'(ovv[0]), 0);

    rst = 1'b1; load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("wrap_d", int'(dq[0]), (i + 1) % 10);
      chk("wrap_tc", int'(tcv[0]), (i == 9) ? 1 : 0);
      chk("wrap_ovf", int'(ovv[0]), (i >= 9) ? 1 : 0);
    end

    load = 1'b1; load_val = 8'd2; up_dn = 1'b0;
    cyc();
    load = 1'b0;
    e = 0;
    for (int k = 0; k < 11; k++) begin
      d_en = pat[k];
      cyc();
      if (pat[k]) e++;
      chk("ps_d", int'(dq[1]), (2 - e / 3 + 10) % 10);
      chk("ps_tc", int'(tcv[1]),
          (pat[k] && e == 9) ? 1 : 0);
    end
    chk("ps_end", int'(dq[1]), 9);

    load = 1'b1; load_val = 8'd8; up_dn = 1'b1;
    d_en = 1'b1;
    cyc();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("sat_d", int'(dq[2]), 9);
      chk("sat_tc", int'(tcv[2]), (k > 0) ? 1 : 0);
    end
    up_dn = 1'b0;
    cyc();
    chk("sat_dn_d", int'(dq[2]), 8);
    chk("sat_dn_tc", int'(tcv[2]), 0);

    load = 1'b1; load_val = 8'd15; up_dn = 1'b1;
    cyc();
    chk("clamp_a", int'(dq[0]), 9);
    chk("clamp_b", int'(dq[1]), 9);
    load = 1'b0; clr_ovf = 1'b1;
    cyc();
    chk("setwins", int'(ovv[0]), 1);
    chk("pre_rst_b", int'(dq[1]), 9);
    d_en = 1'b0;
    cyc();
    chk("clr_ovf", int'(ovv[0]), 0);
    clr_ovf = 1'b0;

`ifdef COUNTER_PROG_CAPTURE_EN
    load = 1'b1; load_val = 8'd5;
    cyc();
    load = 1'b0; cap = 1'b1; d_en = 1'b1; up_dn = 1'b1;
    cyc();
    chk("cap_step_c", int'(cq[0]), 5);
    chk("cap_step_d", int'(dq[0]), 6);
    load = 1'b1; load_val = 8'd0;
    cyc();
    chk("cap_load_c", int'(cq[0]), 6);
    chk("cap_load_d", int'(dq[0]), 0);
    load = 1'b0; cap = 1'b0;
`endif

    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(99) != 0);
      load     = ($urandom_range(15) == 0);
      load_val = W'($urandom_range(15));
      d_en     = ($urandom_range(3) != 0);
      up_dn    = ($urandom_range(9) < 6);
      clr_ovf  = ($urandom_range(7) == 0);
      cap      = ($urandom_range(4) == 0);
      cyc();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_prog.md
Name: counter_prog

Overview:
- Parametrised successor to the fixed 64-bit enable counter.
- Adds configurable width, modulus, up/down direction, parallel load, enable prescaler, wrap-or-saturate mode, a terminal-count pulse and a sticky overflow flag.
- Used wherever the design needs a timebase, event counter or modulo sequencer.
- Single clock domain; feeds status logic and downstream counters, which chain via tc.

Parameters:
- WIDTH, 64: counter width in bits; legal range 2..64.
- MAX_VAL, 2^WIDTH-1: highest count value; count range is 0..MAX_VAL; must be ≥1.
- PRESCALE, 1: number of enabled cycles per count step; legal range 1..65536.
- SATURATE, 0: 0 = wrap at the boundaries; 1 = hold at the boundaries.

Ports:
- clock  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- d_en  in  1  count enable; each high cycle advances the prescaler
- up_dn  in  1  1 = count up, 0 = count down; sampled on the step cycle
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value to load
- clr_ovf  in  1  clears ovf
- d_out  out  WIDTH  current count (registered)
- tc  out  1  terminal-count pulse (registered, one cycle)
- ovf  out  1  sticky boundary-crossing flag

Behaviour:
- All state updates on the rising edge of clock. No combinational path from inputs to outputs.
- Reset: rst=0 at a rising edge sets d_out=0, tc=0, ovf=0 and prescaler=0.
  - Reset overrides every other input.
  - Reset asserted mid-count or mid-prescale discards all progress.
- Priority when rst=1: load > d_en step > hold.
- Load (load=1):
  - d_out <= min(load_val, MAX_VAL); prescaler <= 0; tc <= 0.
  - d_en is ignored that cycle. ovf is unaffected except by clr_ovf.
- Prescaler:
  - Internal counter, ceil(log2(PRESCALE)) bits, minimum 1 bit.
  - On d_en=1, if prescaler==PRESCALE-1 then it resets to 0 and a step occurs; otherwise it increments.
  - d_en=0 holds the prescaler. PRESCALE=1 gives a step on every d_en=1 cycle.
- Step, up (up_dn=1):
  - d_out<MAX_VAL: d_out+1.
  - d_out==MAX_VAL: 0 if SATURATE=0; hold MAX_VAL if SATURATE=1. This is a boundary event.
- Step, down (up_dn=0):
  - d_out>0: d_out-1.
  - d_out==0: MAX_VAL if SATURATE=0; hold 0 if SATURATE=1. This is a boundary event.
- Arithmetic is WIDTH-bit unsigned; no intermediate overflow beyond WIDTH is observable.
- tc:
  - 1 for exactly the one cycle following a boundary-event step, otherwise 0.
  - Repeated saturated steps give one tc pulse per step.
- ovf:
  - Set on every boundary-event step; cleared by clr_ovf=1.
  - If a boundary event and clr_ovf occur in the same cycle, set wins and ovf=1.
- up_dn may change on any cycle. A direction change applies only at the next step; the prescaler is not reset.
- When load_val>MAX_VAL the loaded value clamps to MAX_VAL.

Optional Feature:
- Macro: COUNTER_PROG_CAPTURE_EN.
- Defined:
  - Adds input cap (1 bit) and output cap_out (WIDTH bits).
  - When cap=1, cap_out <= d_out, taking the pre-update value of the same edge.
  - cap_out resets to 0 and holds between captures.
  - A capture in the same cycle as load captures the old value.
- Undefined: the ports are absent, no capture register is built, and all other behaviour is identical.

Test Plan:
- Reset: WIDTH=8, drive rst=0 for 2 cycles with d_en=1, load=1, load_val=8'h55 -> d_out=0, tc=0, ovf=0; first step after rst=1 gives d_out=1.
- Modulo wrap: MAX_VAL=9, PRESCALE=1, SATURATE=0, up_dn=1, d_en=1 for 12 cycles from 0 -> d_out sequence 1..9,0,1,2; tc high exactly the cycle after the 9->0 step; ovf=1 afterwards.
- Prescale and down-count: PRESCALE=3, load_val=2, up_dn=0, d_en=1 for 9 cycles -> d_out changes every 3rd enabled cycle: 1, 0, 9; tc pulses once after the 0->9 step; d_en=0 gaps stall the prescaler without losing phase.
- Saturate: SATURATE=1, MAX_VAL=9, load 8, up_dn=1, 3 steps -> d_out 9, 9, 9; tc pulses on the 2nd and 3rd steps; then up_dn=0, one step -> d_out=8, tc=0.
- Priority and clamping: load=1, d_en=1, load_val=15 with MAX_VAL=9 -> d_out=9, prescaler=0; clr_ovf=1 in the same cycle as a boundary step -> ovf stays 1; clr_ovf alone the next cycle -> ovf=0.
- COUNTER_PROG_CAPTURE_EN: count to 5, pulse cap together with a step -> cap_out=5 while d_out=6; cap together with a load of 0 -> cap_out=6, d_out=0.
